// File: rtl/accum_stage_if.sv
// Product-group bus from the multiplier stage into accum_stage, plus the result bus to activation.
// master = upstream/consumer side, slave = accum_stage.
interface accum_stage_if #(
   parameter int NUM_LANES = 7,
   parameter int PROD_W    = 26,
   parameter int OUT_W     = 32
);
   logic [NUM_LANES*PROD_W-1:0] Product_syn;
   logic                        InValid;
   logic                        InLast;
   logic signed [OUT_W-1:0]     OutSum;
   logic                        OutValid;
   logic                        OutSat;
   logic                        CountErr;

   modport slave (
      input  Product_syn, InValid, InLast,
      output OutSum, OutValid, OutSat, CountErr
   );

   modport master (
      output Product_syn, InValid, InLast,
      input  OutSum, OutValid, OutSat, CountErr
   );
endinterface

// File: rtl/accum_stage.sv
// 7-lane adder tree + per-neuron accumulator with saturated result; InValid&InLast to OutValid is 3 cycles.
// Accepts one group per cycle, never stalls (no backpressure); bubbles leave the running sum untouched.
module accum_stage #(
   parameter int NUM_LANES = 7,
   parameter int PROD_W    = 26,
   parameter int ACC_W     = 40,
   parameter int OUT_W     = 32,
   parameter int GROUPS    = 112
) (
   input  logic          clk,
   input  logic          GlobalReset,
   accum_stage_if.slave  bus
);
   localparam int CNT_W = $clog2(GROUPS + 1) + 1;
   localparam int S1_W  = PROD_W + 1;
   localparam int S2_W  = PROD_W + 3;

   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   logic signed [PROD_W-1:0] lane [NUM_LANES];

   logic                    s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
   logic signed [S1_W-1:0]  s1_sum_q [4];
   logic signed [S1_W-1:0]  s1_sum_d [4];
   logic                    s2_vld_q, s2_vld_d, s2_last_q, s2_last_d;
   logic signed [S2_W-1:0]  s2_sum_q, s2_sum_d;
   logic signed [ACC_W-1:0] acc_q, acc_d, acc_next;
   logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_next;
   logic signed [OUT_W-1:0] out_sum_q, out_sum_d;
   logic                    out_vld_q, out_vld_d;
   logic                    out_sat_q, out_sat_d;
   logic                    cnt_err_q, cnt_err_d;

   always_comb begin
      for (int k = 0; k < NUM_LANES; k++) begin
         lane[k] = bus.Product_syn[k*PROD_W +: PROD_W];
      end
   end

   always_comb begin
      // Size casts of signed operands sign-extend at every width step.
      s1_vld_d    = bus.InValid;
      s1_last_d   = bus.InValid & bus.InLast;
      s1_sum_d[0] = S1_W'(lane[0]) + S1_W'(lane[1]);
      s1_sum_d[1] = S1_W'(lane[2]) + S1_W'(lane[3]);
      s1_sum_d[2] = S1_W'(lane[4]) + S1_W'(lane[5]);
      s1_sum_d[3] = S1_W'(lane[6]);

      s2_vld_d  = s1_vld_q;
      s2_last_d = s1_last_q;
      s2_sum_d  = S2_W'(s1_sum_q[0]) + S2_W'(s1_sum_q[1])
                + S2_W'(s1_sum_q[2]) + S2_W'(s1_sum_q[3]);

      acc_next = acc_q + ACC_W'(s2_sum_q);
      cnt_next = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

      acc_d     = acc_q;
      cnt_d     = cnt_q;
      out_sum_d = out_sum_q;
      out_vld_d = 1'b0;
      out_sat_d = out_sat_q;
      cnt_err_d = cnt_err_q;

      if (s2_vld_q) begin
         if (s2_last_q) begin
            out_vld_d = 1'b1;
            if (acc_next > SAT_MAX) begin
               out_sum_d = SAT_MAX[OUT_W-1:0];
               out_sat_d = 1'b1;
            end else if (acc_next < SAT_MIN) begin
               out_sum_d = SAT_MIN[OUT_W-1:0];
               out_sat_d = 1'b1;
            end else begin
               out_sum_d = acc_next[OUT_W-1:0];
               out_sat_d = 1'b0;
            end
            cnt_err_d = (cnt_next != CNT_W'(GROUPS));
            acc_d     = '0;
            cnt_d     = '0;
         end else begin
            acc_d = acc_next;
            cnt_d = cnt_next;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (GlobalReset) begin
         s1_vld_q  <= 1'b0;
         s1_last_q <= 1'b0;
         s1_sum_q  <= '{default: '0};
         s2_vld_q  <= 1'b0;
         s2_last_q <= 1'b0;
         s2_sum_q  <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         out_sum_q <= '0;
         out_vld_q <= 1'b0;
         out_sat_q <= 1'b0;
         cnt_err_q <= 1'b0;
      end else begin
         s1_vld_q  <= s1_vld_d;
         s1_last_q <= s1_last_d;
         s1_sum_q  <= s1_sum_d;
         s2_vld_q  <= s2_vld_d;
         s2_last_q <= s2_last_d;
         s2_sum_q  <= s2_sum_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         out_sum_q <= out_sum_d;
         out_vld_q <= out_vld_d;
         out_sat_q <= out_sat_d;
         cnt_err_q <= cnt_err_d;
      end
   end

   assign bus.OutSum   = out_sum_q;
   assign bus.OutValid = out_vld_q;
   assign bus.OutSat   = out_sat_q;
   assign bus.CountErr = cnt_err_q;
endmodule

// File: doc/accum_stage.md
Name: accum_stage

Overview:
- Consumes the 7-lane signed 26-bit product bus produced by the multiplier stage one cycle after each product group is valid.
- Reduces each 7-product group with a registered adder tree, then accumulates successive groups into one dot-product result per neuron.
- Delivers a saturated result with a one-cycle valid pulse to the activation stage.
- Framing (valid/last) is carried alongside the product data by the upstream control.

Parameters:
NUM_LANES, 7, products per group (fixed tree structure assumes 7)
PROD_W, 26, width of each signed product lane
ACC_W, 40, internal accumulator width (signed)
OUT_W, 32, width of the signed saturated result
GROUPS, 112, expected groups per neuron (784 inputs / 7)

Ports:
clk  in  1  clock, all logic rising-edge
GlobalReset  in  1  synchronous active-high reset
Product_syn  in  NUM_LANES*PROD_W  lane k = bits [26k+25:26k], signed two's complement
InValid  in  1  Product_syn holds a valid group this cycle
InLast  in  1  qualified by InValid; this group is the final one of the neuron
OutSum  out  OUT_W  signed saturated dot product
OutValid  out  1  one-cycle pulse, OutSum valid
OutSat  out  1  qualified by OutValid; result was clipped
CountErr  out  1  qualified by OutValid; group count != GROUPS

Behaviour:
- One clock, synchronous active-high reset: on GlobalReset=1 at a rising edge, every register clears. Cleared registers: pipeline valid/last bits, partial sums, accumulator, group counter, OutSum, OutValid, OutSat, CountErr.
- All outputs reset to 0.
- S1 (edge after input): register pairwise sums p0+p1, p2+p3, p4+p5 and sign-extended p6, each PROD_W+1 bits. Register valid/last alongside.
- S2: register the tree total, PROD_W+3 bits, sign-extended. Register valid/last alongside.
- S3 (accumulate), when S2 valid:
  - acc_next = acc + sign-extended tree total, computed at ACC_W with no internal saturation. The defaults cannot overflow: 7*112*2^25 < 2^39.
  - cnt_next = cnt + 1.
  - If last=0: acc <= acc_next, cnt <= cnt_next.
  - If last=1:
    - OutSum <= sat(acc_next), OutValid <= 1.
    - OutSat <= 1 if acc_next lies outside [-2^(OUT_W-1), 2^(OUT_W-1)-1], else 0.
    - CountErr <= (cnt_next != GROUPS).
    - acc <= 0, cnt <= 0.
- S3, when S2 not valid: acc and cnt hold; OutValid <= 0.
- OutValid is high for exactly one cycle per InLast. OutSum, OutSat and CountErr hold their values until the next result.
- Latency: from the input cycle carrying InValid&InLast to OutValid high is 3 cycles.
- Throughput: one group per cycle, no backpressure. Bubbles (InValid=0) may appear anywhere in a neuron and do not alter the result.
- Back-to-back neurons: a group with InValid=1 immediately following a last group starts a fresh neuron from acc=0. No dead cycle is required.
- Single-group neuron (InValid&InLast on the first group) is legal. OutSum equals that group's sum; CountErr=1 unless GROUPS=1.
- InLast with InValid=0 is ignored.
- Counter saturates at its maximum value and does not wrap. Counter width is ceil(log2(GROUPS+1))+1.
- Reset mid-neuron discards all in-flight groups and the partial sum. No OutValid is produced for the aborted neuron. The first valid group after reset deasserts starts a new neuron.
- Sign handling: lanes are always interpreted signed. Sign extension is required at every width growth; truncation never occurs before saturation.

Test Plan:
- Single group, all 7 lanes = 1, InValid=InLast=1, GROUPS=1 -> OutValid exactly 3 cycles later, OutSum=7, OutSat=0, CountErr=0.
- 112 groups, lanes = {-1, 2^25-1, 0, 0, 0, 0, -2^25}, last on group 112 -> OutSum = 112*(-2) = -224, CountErr=0, single OutValid pulse.
- Bench OUT_W=26, 112 groups all lanes = 2^25-1 -> OutSum = 2^25-1, OutSat=1. Repeat with all lanes = -2^25 -> OutSum = -2^25, OutSat=1.
- Two neurons back-to-back without a gap (first: 112 groups of lane0=3, rest 0; second: 112 groups of lane0=-1) with random InValid bubbles inserted -> OutSum 336 then -112, two OutValid pulses, no cross-contamination.
- InLast after 50 groups -> OutSum = sum of those 50 groups, CountErr=1. Next neuron of 112 groups -> CountErr=0.
- GlobalReset pulsed for 1 cycle after 60 groups, then a full 112-group neuron of lane0=1 -> no output for the aborted neuron, then OutSum=112. All outputs read 0 during and immediately after reset.
